// File: rtl/msd_pkg.sv
// Shared types and constants for the memory-side command sequencer.
// Command/oper encodings, address field positions and default timings.
package msd_pkg;

   typedef enum logic [2:0] {
      CMD_ACT0 = 3'd0,
      CMD_ACT1 = 3'd1,
      CMD_RD0  = 3'd2,
      CMD_RD1  = 3'd3,
      CMD_WR0  = 3'd4,
      CMD_WR1  = 3'd5,
      CMD_PRE  = 3'd6
   } cmd_t;

   typedef enum logic [3:0] {
      S_IDLE, S_ACT0, S_ACT1, S_WAIT_RCD, S_CAS0,
      S_CAS1, S_WAIT_CAS, S_PRE, S_WAIT_RP, S_ERR
   } state_t;

   localparam logic [1:0] OPER_RD  = 2'd0;
   localparam logic [1:0] OPER_IF  = 2'd1;
   localparam logic [1:0] OPER_WR  = 2'd2;
   localparam logic [1:0] OPER_ILL = 2'd3;

   localparam int ADDR_W   = 36;
   localparam int CHAN_BIT = 6;
   localparam int BG_LSB   = 7;
   localparam int BG_W     = 3;
   localparam int BA_LSB   = 10;
   localparam int BA_W     = 2;
   localparam int COL_LSB  = 12;
   localparam int COL_W    = 6;
   localparam int ROW_LSB  = 18;
   localparam int ROW_W    = 16;

   localparam int T_RCD_DEF = 39;
   localparam int T_RTP_DEF = 18;
   localparam int T_WTP_DEF = 48;
   localparam int T_RP_DEF  = 39;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/msd_delay_cnt.sv
// Loadable down-counter with zero flag; saturates at zero so it never wraps.
module msd_delay_cnt #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/msd_cmd_seq.sv
// Single-request DRAM command sequencer: ACT0/ACT1, CAS0/CAS1, PRE with
// parameterised ACT->CAS, CAS->PRE and PRE->ACT spacing.
module msd_cmd_seq
   import msd_pkg::*;
#(
   parameter int T_RCD = T_RCD_DEF,
   parameter int T_RTP = T_RTP_DEF,
   parameter int T_WTP = T_WTP_DEF,
   parameter int T_RP  = T_RP_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_oper,
   input  logic [35:0] req_addr,
   output logic        cmd_valid,
   output logic [2:0]  cmd_type,
   output logic        cmd_chan,
   output logic [2:0]  cmd_bg,
   output logic [1:0]  cmd_ba,
   output logic [15:0] cmd_row,
   output logic [5:0]  cmd_col,
   output logic        req_done,
   output logic        req_err
);

   localparam int CNT_W = $clog2(max4(T_RCD, T_RTP, T_WTP, T_RP) + 1);
   // A wait state spans N-2 cycles; the counter holds the cycles left after
   // the current one, so it is loaded with N-3 and exits on zero.
   localparam logic [CNT_W-1:0] RCD_LD = CNT_W'((T_RCD > 2) ? T_RCD - 3 : 0);
   localparam logic [CNT_W-1:0] RTP_LD = CNT_W'((T_RTP > 2) ? T_RTP - 3 : 0);
   localparam logic [CNT_W-1:0] WTP_LD = CNT_W'((T_WTP > 2) ? T_WTP - 3 : 0);
   localparam logic [CNT_W-1:0] RP_LD  = CNT_W'((T_RP  > 2) ? T_RP  - 3 : 0);

   state_t       state_q, state_d;
   logic         rdy_q;
   logic         wr_q, wr_d;
   logic         chan_q, chan_d;
   logic [2:0]   bg_q, bg_d;
   logic [1:0]   ba_q, ba_d;
   logic [15:0]  row_q, row_d;
   logic [5:0]   col_q, col_d;

   logic             acc;
   logic             cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0] cnt_val;
   logic             cmd_vld;
   cmd_t             cmd_typ;
   logic             cas_long;
   logic             addr_unused;

   assign addr_unused = ^{req_addr[35:34], req_addr[5:0]};

   // rdy_q keeps req_ready low through reset and the edge that releases it.
   assign req_ready = rdy_q && (state_q == S_IDLE);
   assign acc       = req_valid && req_ready;
   assign cas_long  = wr_q ? (T_WTP > 2) : (T_RTP > 2);

   always_comb begin
      state_d  = state_q;
      cnt_load = 1'b0;
      cnt_val  = '0;
      cnt_dec  = 1'b0;
      cmd_vld  = 1'b0;
      cmd_typ  = CMD_ACT0;
      req_done = 1'b0;
      req_err  = 1'b0;
      case (state_q)
         S_IDLE:
            if (acc) state_d = (req_oper == OPER_ILL) ? S_ERR : S_ACT0;
         S_ACT0: begin
            cmd_vld = 1'b1;
            cmd_typ = CMD_ACT0;
            state_d = S_ACT1;
         end
         S_ACT1: begin
            cmd_vld = 1'b1;
            cmd_typ = CMD_ACT1;
            if (T_RCD > 2) begin
               state_d  = S_WAIT_RCD;
               cnt_load = 1'b1;
               cnt_val  = RCD_LD;
            end else begin
               state_d = S_CAS0;
            end
         end
         S_WAIT_RCD:
            if (cnt_zero) state_d = S_CAS0;
            else          cnt_dec = 1'b1;
         S_CAS0: begin
            cmd_vld = 1'b1;
            cmd_typ = wr_q ? CMD_WR0 : CMD_RD0;
            state_d = S_CAS1;
         end
         S_CAS1: begin
            cmd_vld = 1'b1;
            cmd_typ = wr_q ? CMD_WR1 : CMD_RD1;
            if (cas_long) begin
               state_d  = S_WAIT_CAS;
               cnt_load = 1'b1;
               cnt_val  = wr_q ? WTP_LD : RTP_LD;
            end else begin
               state_d = S_PRE;
            end
         end
         S_WAIT_CAS:
            if (cnt_zero) state_d = S_PRE;
            else          cnt_dec = 1'b1;
         S_PRE: begin
            cmd_vld  = 1'b1;
            cmd_typ  = CMD_PRE;
            req_done = 1'b1;
            if (T_RP > 2) begin
               state_d  = S_WAIT_RP;
               cnt_load = 1'b1;
               cnt_val  = RP_LD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT_RP:
            if (cnt_zero) state_d = S_IDLE;
            else          cnt_dec = 1'b1;
         S_ERR: begin
            req_err = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_d   = wr_q;
      chan_d = chan_q;
      bg_d   = bg_q;
      ba_d   = ba_q;
      row_d  = row_q;
      col_d  = col_q;
      if (acc) begin
         wr_d   = (req_oper == OPER_WR);
         chan_d = req_addr[CHAN_BIT];
         bg_d   = req_addr[BG_LSB  +: BG_W];
         ba_d   = req_addr[BA_LSB  +: BA_W];
         row_d  = req_addr[ROW_LSB +: ROW_W];
         col_d  = req_addr[COL_LSB +: COL_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         rdy_q   <= 1'b0;
         wr_q    <= 1'b0;
         chan_q  <= 1'b0;
         bg_q    <= '0;
         ba_q    <= '0;
         row_q   <= '0;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         rdy_q   <= 1'b1;
         wr_q    <= wr_d;
         chan_q  <= chan_d;
         bg_q    <= bg_d;
         ba_q    <= ba_d;
         row_q   <= row_d;
         col_q   <= col_d;
      end
   end

   msd_delay_cnt #(.W(CNT_W)) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   assign cmd_valid = cmd_vld;
   assign cmd_type  = cmd_vld ? 3'(cmd_typ) : 3'd0;
   assign cmd_chan  = cmd_vld ? chan_q : 1'b0;
   assign cmd_bg    = cmd_vld ? bg_q   : 3'd0;
   assign cmd_ba    = cmd_vld ? ba_q   : 2'd0;
   assign cmd_row   = cmd_vld ? row_q  : 16'd0;
   assign cmd_col   = cmd_vld ? col_q  : 6'd0;

endmodule

// File: tb/tb_msd_cmd_seq.sv
// Scoreboard bench for msd_cmd_seq: main build (T_RCD=4,T_RTP=3,T_WTP=5,T_RP=3)
// plus a T_RCD=2 build, with directed vectors and hand-computed expectations.
module tb_msd_cmd_seq;

   localparam logic [2:0] ACT0 = 3'd0, ACT1 = 3'd1, RD0 = 3'd2, RD1 = 3'd3,
                          WR0 = 3'd4, WR1 = 3'd5, PRE = 3'd6;

   typedef struct packed {
      int          cyc;
      logic [2:0]  typ;
      logic        ch;
      logic [2:0]  bg;
      logic [1:0]  ba;
      logic [15:0] row;
      logic [5:0]  col;
   } exp_t;

   typedef struct packed {
      logic [1:0]  oper;
      logic [35:0] addr;
      logic        ch;
      logic [2:0]  bg;
      logic [1:0]  ba;
      logic [15:0] row;
      logic [5:0]  col;
   } vec_t;

   localparam vec_t V_RD  = '{oper: 2'd0, addr: 36'h123456ABC, ch: 1'b0, bg: 3'd5, ba: 2'd2, row: 16'h48D1, col: 6'd22};
   localparam vec_t V_WR  = '{oper: 2'd2, addr: 36'h123456ABC, ch: 1'b0, bg: 3'd5, ba: 2'd2, row: 16'h48D1, col: 6'd22};
   localparam vec_t V_IF1 = '{oper: 2'd1, addr: 36'hFFFFFFFFF, ch: 1'b1, bg: 3'd7, ba: 2'd3, row: 16'hFFFF, col: 6'd63};
   localparam vec_t V_CH  = '{oper: 2'd0, addr: 36'h000000040, ch: 1'b1, bg: 3'd0, ba: 2'd0, row: 16'h0000, col: 6'd0};
   localparam vec_t V_ILL = '{oper: 2'd3, addr: 36'h123456ABC, ch: 1'b0, bg: 3'd0, ba: 2'd0, row: 16'h0000, col: 6'd0};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid [2];
   logic        req_ready [2];
   logic [1:0]  req_oper;
   logic [35:0] req_addr;
   logic        cmd_valid [2];
   logic [2:0]  cmd_type  [2];
   logic        cmd_chan  [2];
   logic [2:0]  cmd_bg    [2];
   logic [1:0]  cmd_ba    [2];
   logic [15:0] cmd_row   [2];
   logic [5:0]  cmd_col   [2];
   logic        req_done  [2];
   logic        req_err   [2];

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   msd_cmd_seq #(.T_RCD(4), .T_RTP(3), .T_WTP(5), .T_RP(3)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_oper(req_oper), .req_addr(req_addr),
      .cmd_valid(cmd_valid[0]), .cmd_type(cmd_type[0]), .cmd_chan(cmd_chan[0]),
      .cmd_bg(cmd_bg[0]), .cmd_ba(cmd_ba[0]), .cmd_row(cmd_row[0]), .cmd_col(cmd_col[0]),
      .req_done(req_done[0]), .req_err(req_err[0])
   );

   msd_cmd_seq #(.T_RCD(2), .T_RTP(3), .T_WTP(5), .T_RP(3)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_oper(req_oper), .req_addr(req_addr),
      .cmd_valid(cmd_valid[1]), .cmd_type(cmd_type[1]), .cmd_chan(cmd_chan[1]),
      .cmd_bg(cmd_bg[1]), .cmd_ba(cmd_ba[1]), .cmd_row(cmd_row[1]), .cmd_col(cmd_col[1]),
      .req_done(req_done[1]), .req_err(req_err[1])
   );

   exp_t qc [2][$];
   int   qd [2][$];
   int   qe [2][$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic ok, input string detail);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: %s", name, detail);
      end
   endtask

   function automatic exp_t mk(input int c, input logic [2:0] t, input vec_t v);
      exp_t e;
      e.cyc = c; e.typ = t; e.ch = v.ch; e.bg = v.bg; e.ba = v.ba; e.row = v.row; e.col = v.col;
      return e;
   endfunction

   // Expected commands for a request accepted in cycle a on build d.
   task automatic push_req(input int d, input int a, input vec_t v);
      int rcd, tcas;
      rcd  = (d == 1) ? 2 : 4;
      tcas = (v.oper == 2'd2) ? 5 : 3;
      if (v.oper == 2'd3) begin
         qe[d].push_back(a + 1);
      end else begin
         qc[d].push_back(mk(a + 1, ACT0, v));
         qc[d].push_back(mk(a + 2, ACT1, v));
         qc[d].push_back(mk(a + 1 + rcd, (v.oper == 2'd2) ? WR0 : RD0, v));
         qc[d].push_back(mk(a + 2 + rcd, (v.oper == 2'd2) ? WR1 : RD1, v));
         qc[d].push_back(mk(a + 1 + rcd + tcas, PRE, v));
         qd[d].push_back(a + 1 + rcd + tcas);
      end
   endtask

   task automatic mon(input int d);
      exp_t e;
      int   c;
      if (cmd_valid[d]) begin
         if (qc[d].size() == 0) begin
            chk("unexpected_cmd", 1'b0, $sformatf("dut%0d cyc %0d got type %0d, required no command", d, cyc, cmd_type[d]));
         end else begin
            e = qc[d].pop_front();
            chk($sformatf("cmd_type%0d", e.typ),
                cyc == e.cyc && cmd_type[d] == e.typ && cmd_chan[d] == e.ch && cmd_bg[d] == e.bg &&
                cmd_ba[d] == e.ba && cmd_row[d] == e.row && cmd_col[d] == e.col,
                $sformatf("dut%0d got cyc %0d type %0d ch %0d bg %0d ba %0d row %h col %0d, required cyc %0d type %0d ch %0d bg %0d ba %0d row %h col %0d",
                          d, cyc, cmd_type[d], cmd_chan[d], cmd_bg[d], cmd_ba[d], cmd_row[d], cmd_col[d],
                          e.cyc, e.typ, e.ch, e.bg, e.ba, e.row, e.col));
         end
      end else begin
         chk("idle_fields_zero", {cmd_type[d], cmd_chan[d], cmd_bg[d], cmd_ba[d], cmd_row[d], cmd_col[d]} == '0,
             $sformatf("dut%0d cyc %0d got type %0d ch %0d bg %0d ba %0d row %h col %0d, required all 0",
                       d, cyc, cmd_type[d], cmd_chan[d], cmd_bg[d], cmd_ba[d], cmd_row[d], cmd_col[d]));
      end
      if (req_done[d]) begin
         c = (qd[d].size() == 0) ? -1 : qd[d].pop_front();
         chk("req_done", c == cyc, $sformatf("dut%0d done at cyc %0d, required cyc %0d", d, cyc, c));
      end
      if (req_err[d]) begin
         c = (qe[d].size() == 0) ? -1 : qe[d].pop_front();
         chk("req_err", c == cyc, $sformatf("dut%0d err at cyc %0d, required cyc %0d", d, cyc, c));
      end
   endtask

   // Present v on build d, wait (bounded) for acceptance, return its cycle.
   task automatic run(input int d, input vec_t v, input logic hold, output int a);
      req_oper     = v.oper;
      req_addr     = v.addr;
      req_valid[d] = 1'b1;
      for (int i = 0; i < 100 && !req_ready[d]; i++) @(negedge clk);
      if (!req_ready[d]) chk("ready_timeout", 1'b0, $sformatf("dut%0d req_ready 0 after 100 cycles, required 1", d));
      a = cyc;
      push_req(d, a, v);
      @(negedge clk);
      req_valid[d] = hold;
   endtask

   task automatic wait_cyc(input int c);
      for (int i = 0; i < 200 && cyc < c; i++) @(negedge clk);
   endtask

   initial begin
      int a, a2;
      req_valid[0] = 1'b0;
      req_valid[1] = 1'b0;
      req_oper     = 2'd0;
      req_addr     = '0;

      fork
         forever begin
            @(negedge clk);
            if (rst_n) begin
               mon(0);
               mon(1);
            end
         end
      join_none

      repeat (3) @(negedge clk);
      chk("reset_outputs", {req_ready[0], cmd_valid[0], cmd_type[0], cmd_row[0], req_done[0], req_err[0],
                            req_ready[1], cmd_valid[1], req_done[1], req_err[1]} == '0,
          $sformatf("got ready %0d valid %0d done %0d err %0d, required all 0",
                    req_ready[0], cmd_valid[0], req_done[0], req_err[0]));
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", req_ready[0] && req_ready[1],
          $sformatf("got %0d/%0d, required 1/1", req_ready[0], req_ready[1]));

      // Read: ready low until p+T_RP-1, i.e. accept cycle + 10.
      run(0, V_RD, 1'b0, a);
      wait_cyc(a + 9);
      chk("ready_low_in_wait_rp", !req_ready[0], $sformatf("cyc %0d got %0d, required 0", cyc, req_ready[0]));
      @(negedge clk);
      chk("ready_reassert", req_ready[0] && cyc == a + 10,
          $sformatf("cyc %0d got %0d, required 1 at cyc %0d", cyc, req_ready[0], a + 10));

      // Write with illegal req_valid toggling while busy.
      run(0, V_WR, 1'b0, a);
      req_oper = 2'd3;
      for (int i = 0; i < 4; i++) begin
         req_valid[0] = (i % 2 == 0);
         @(negedge clk);
      end
      req_valid[0] = 1'b0;

      run(0, V_IF1, 1'b0, a);

      // Back-to-back reads with req_valid held high.
      run(0, V_RD, 1'b1, a);
      run(0, V_CH, 1'b0, a2);
      chk("b2b_accept_gap", a2 == a + 10, $sformatf("second accept at %0d, required %0d", a2, a + 10));

      // Illegal oper.
      run(0, V_ILL, 1'b0, a);
      chk("ready_low_in_err", !req_ready[0], $sformatf("cyc %0d got %0d, required 0", cyc, req_ready[0]));
      @(negedge clk);
      chk("ready_after_err", req_ready[0] && cyc == a + 2,
          $sformatf("cyc %0d got %0d, required 1 at cyc %0d", cyc, req_ready[0], a + 2));

      // Reset in cycle 4 of a read.
      run(0, V_RD, 1'b0, a);
      wait_cyc(a + 4);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_reset_outputs", {req_ready[0], cmd_valid[0], cmd_type[0], cmd_chan[0], cmd_bg[0], cmd_ba[0],
                                cmd_row[0], cmd_col[0], req_done[0], req_err[0]} == '0,
          $sformatf("got ready %0d valid %0d type %0d done %0d err %0d, required all 0",
                    req_ready[0], cmd_valid[0], cmd_type[0], req_done[0], req_err[0]));
      qc[0].delete();
      qd[0].delete();
      qe[0].delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_mid_reset", req_ready[0], $sformatf("got %0d, required 1", req_ready[0]));
      run(0, V_CH, 1'b0, a);

      // T_RCD=2 build: RD0 right after ACT1.
      run(1, V_IF1, 1'b0, a);

      for (int i = 0; i < 100 && (qc[0].size() + qc[1].size() + qd[0].size() + qd[1].size() +
                                  qe[0].size() + qe[1].size()) != 0; i++) @(negedge clk);
      chk("drain", (qc[0].size() + qc[1].size() + qd[0].size() + qd[1].size() + qe[0].size() + qe[1].size()) == 0,
          $sformatf("got %0d/%0d commands outstanding, required 0/0", qc[0].size(), qc[1].size()));
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/msd_cmd_seq.md
MSD_CMD_SEQ -- requirements
Module: msd_cmd_seq

Interface
REQ-001 The block SHALL have parameter T_RCD, default 39, giving ACT0-to-CAS0 spacing in cycles; legal values are 2 or more.
REQ-002 The block SHALL have parameter T_RTP, default 18, giving RD0-to-PRE spacing in cycles; legal values are 2 or more.
REQ-003 The block SHALL have parameter T_WTP, default 48, giving WR0-to-PRE spacing in cycles; legal values are 2 or more.
REQ-004 The block SHALL have parameter T_RP, default 39, giving PRE-to-next-ACT0 spacing in cycles; legal values are 2 or more.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset:
- clk, input, 1 bit, sole clock.
- rst_n, input, 1 bit, asynchronous, active-low reset.
REQ-006 The request ports SHALL be:
- req_valid, input, 1 bit, head of the controller queue is valid.
- req_ready, output, 1 bit, the sequencer can accept a request.
- req_oper, input, 2 bits: 0 = data read, 1 = instruction fetch, 2 = write, 3 = illegal.
- req_addr, input, 36 bits, physical address.
REQ-007 The command ports SHALL be:
- cmd_valid, output, 1 bit, a command is issued this cycle.
- cmd_type, output, 3 bits, cmd_t encoding.
- cmd_chan, output, 1 bit, channel.
- cmd_bg, output, 3 bits, bank group.
- cmd_ba, output, 2 bits, bank.
- cmd_row, output, 16 bits, row.
- cmd_col, output, 6 bits, column.
REQ-008 The status ports SHALL be:
- req_done, output, 1 bit, one-cycle pulse when PRE is issued.
- req_err, output, 1 bit, one-cycle pulse when an illegal request is dropped.

Function
REQ-009 A request SHALL be accepted only in a cycle where req_valid and req_ready are both 1; req_ready SHALL depend only on state.
REQ-010 On acceptance, the block SHALL latch the address fields and hold them stable until the request completes:
- chan = addr[6]
- bg = addr[9:7]
- ba = addr[11:10]
- col = addr[17:12]
- row = addr[33:18]
REQ-011 The FSM SHALL have the states IDLE, ACT0, ACT1, WAIT_RCD, CAS0, CAS1, WAIT_CAS, PRE, WAIT_RP and ERR.
REQ-012 In IDLE, req_ready SHALL be 1; on acceptance with oper 0, 1 or 2 the next state SHALL be ACT0, and with oper 3 the next state SHALL be ERR.
REQ-013 If acceptance happens in cycle a, ACT0 SHALL be issued in cycle a+1 and ACT1 in cycle a+2.
REQ-014 CAS0 SHALL be issued exactly T_RCD cycles after ACT0, and CAS1 one cycle after CAS0; when T_RCD = 2, WAIT_RCD SHALL be skipped.
REQ-015 CAS0/CAS1 SHALL be RD0/RD1 for oper 0 and 1, and WR0/WR1 for oper 2.
REQ-016 PRE SHALL be issued exactly T_RTP (reads) or T_WTP (writes) cycles after CAS0; PRE SHALL be issued for writes too, never REF.
REQ-017 req_done SHALL pulse in the cycle PRE is issued.
REQ-018 With PRE in cycle p, req_ready SHALL reassert in cycle p+T_RP-1, so the next ACT0 issues no earlier than p+T_RP.
REQ-019 In ERR, the block SHALL issue no command, pulse req_err for one cycle, then return to IDLE.
REQ-020 cmd_valid SHALL be 1 only in the ACT0, ACT1, CAS0, CAS1 and PRE states; the address fields SHALL be 0 when cmd_valid is 0.
REQ-021 The wait counters SHALL be wide enough for the largest parameter, and SHALL never underflow or wrap.
REQ-022 req_valid toggling while the block is busy SHALL have no effect.

Reset
REQ-023 Asserting rst_n low SHALL force IDLE immediately, including in the middle of a sequence, and discard the in-flight request.
REQ-024 While in reset, all outputs SHALL be 0, except req_ready, which SHALL be 0 during reset and 1 from the first clock after deassertion.

Structure
REQ-025 Package msd_pkg SHALL hold:
- cmd_t: ACT0=0, ACT1=1, RD0=2, RD1=3, WR0=4, WR1=5, PRE=6.
- the oper constants.
- the address-field bit positions.
- the default timing constants.
REQ-026 Sub-module msd_delay_cnt, a loadable down-counter with a zero flag, SHALL implement WAIT_RCD, WAIT_CAS and WAIT_RP.

Verification
All scenarios use T_RCD=4, T_RTP=3, T_WTP=5, T_RP=3.
REQ-027 Read oper 0, addr 36'h123456ABC, accepted in cycle 0, SHALL produce:
- ACT0@1, ACT1@2, RD0@5, RD1@6, PRE@8.
- chan=0, bg=5, ba=2, row=16'h48D1, col=22.
- req_done@8, req_ready@10.
REQ-028 Write oper 2, same address, accepted in cycle 0, SHALL produce ACT0@1, ACT1@2, WR0@5, WR1@6, PRE@10, with no REF issued.
REQ-029 Two back-to-back reads with req_valid held high SHALL give the second ACT0 exactly 3 cycles after the first PRE.
REQ-030 Oper 3 accepted in cycle 0 SHALL give req_err@1, no cmd_valid, and req_ready@2.
REQ-031 rst_n asserted at cycle 4 of a read SHALL give all outputs 0 immediately, and a new request after release SHALL restart at ACT0.
REQ-032 A T_RCD=2 build SHALL issue RD0 directly after ACT1.
